rv_alu_core: RTL and testbench

Multi-cycle RV32I/RV64I integer-ALU core: accepts one instruction per valid/ready handshake, decodes it, reads an internal register file, executes the OP-IMM or OP operation and writes back. It replaces the single-shot combinational decode/execute path with a register file, an FSM and an instruction handshake. XLEN and register count are parametrised, and illegal instructions are flagged explicitly.

---
 rtl/rv_alu_core_if.sv | 36 +++
 rtl/rv_alu_core.sv | 207 ++++++++++++++++++++
 tb/tb_rv_alu_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rv_alu_core_if.sv
// Instruction handshake and writeback bundle for rv_alu_core.
// master drives instructions; slave is the core.
interface rv_alu_core_if #(
   parameter int XLEN = 32
);
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal;
   logic [31:0]     retire_count;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready,
      input  wb_valid,
      input  wb_rd,
      input  wb_data,
      input  illegal,
      input  retire_count
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready,
      output wb_valid,
      output wb_rd,
      output wb_data,
      output illegal,
      output retire_count
   );
endinterface

// File: rtl/rv_alu_core.sv
// Multi-cycle RV32I/RV64I integer ALU core with register file.
// IDLE -> DECODE -> EXEC -> WB, one instruction per four cycles.
module rv_alu_core #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input logic         clk,
   input logic         rst,
   rv_alu_core_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam int AW = $clog2(NUM_REGS);
   localparam logic [5:0] NR = 6'(NUM_REGS);

   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP  = 7'b0110011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] op_a_q, op_a_d;
   logic [XLEN-1:0] op_b_q, op_b_d;
   logic [2:0]      f3_q, f3_d;
   logic            alt_q, alt_d;
   logic            bad_q, bad_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            wb_valid_q, wb_valid_d;
   logic            illegal_q, illegal_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [31:0]     retire_q, retire_d;
   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] regs_d [NUM_REGS];

   logic [6:0]      opc;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            is_imm, is_op;
   logic            dec_bad;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] alu;
   logic [SW-1:0]   shamt;

   assign opc = instr_q[6:0];
   assign rd  = instr_q[11:7];
   assign f3  = instr_q[14:12];
   assign rs1 = instr_q[19:15];
   assign rs2 = instr_q[24:20];
   assign f7  = instr_q[31:25];

   assign is_imm = (opc == OPC_IMM);
   assign is_op  = (opc == OPC_OP);
   assign imm    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};

   // Out-of-range indices only occur on illegal words, so truncation is safe.
   assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1[AW-1:0]];
   assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2[AW-1:0]];

   always_comb begin
      dec_bad = 1'b0;
      unique case (1'b1)
         is_op: begin
            if (f7 == 7'b0100000)
               dec_bad = !((f3 == 3'b000) || (f3 == 3'b101));
            else
               dec_bad = (f7 != 7'b0000000);
         end
         is_imm: begin
            if (f3 == 3'b001)
               dec_bad = (instr_q[31:26] != 6'b000000);
            else if (f3 == 3'b101)
               dec_bad = (instr_q[31:26] != 6'b000000)
                      && (instr_q[31:26] != 6'b010000);
            if ((f3 == 3'b001 || f3 == 3'b101)
                && (XLEN == 32) && instr_q[25])
               dec_bad = 1'b1;
         end
         default: dec_bad = 1'b1;
      endcase
      if ({1'b0, rd} >= NR || {1'b0, rs1} >= NR)
         dec_bad = 1'b1;
      if (is_op && {1'b0, rs2} >= NR)
         dec_bad = 1'b1;
   end

   assign shamt = op_b_q[SW-1:0];

   always_comb begin
      alu = '0;
      unique case (f3_q)
         3'b000: alu = alt_q ? op_a_q - op_b_q : op_a_q + op_b_q;
         3'b001: alu = op_a_q << shamt;
         3'b010: alu = {{(XLEN-1){1'b0}},
                        $signed(op_a_q) < $signed(op_b_q)};
         3'b011: alu = {{(XLEN-1){1'b0}}, op_a_q < op_b_q};
         3'b100: alu = op_a_q ^ op_b_q;
         3'b101: alu = alt_q ? XLEN'($signed(op_a_q) >>> shamt)
                             : op_a_q >> shamt;
         3'b110: alu = op_a_q | op_b_q;
         3'b111: alu = op_a_q & op_b_q;
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      f3_d       = f3_q;
      alt_d      = alt_q;
      bad_d      = bad_q;
      res_d      = res_q;
      wb_valid_d = 1'b0;
      illegal_d  = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      retire_d   = retire_q;
      regs_d     = regs_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            op_a_d  = rs1_val;
            op_b_d  = is_op ? rs2_val : imm;
            f3_d    = f3;
            alt_d   = (f3 == 3'b101) ? instr_q[30]
                                     : (is_op && instr_q[30]);
            bad_d   = dec_bad;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu;
            state_d = S_WB;
         end
         S_WB: begin
            if (bad_q) begin
               illegal_d = 1'b1;
            end else begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd;
               wb_data_d  = res_q;
               retire_d   = retire_q + 32'd1;
               if (rd != 5'd0)
                  regs_d[rd[AW-1:0]] = res_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         f3_q       <= '0;
         alt_q      <= 1'b0;
         bad_q      <= 1'b0;
         res_q      <= '0;
         wb_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         retire_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         f3_q       <= f3_d;
         alt_q      <= alt_d;
         bad_q      <= bad_d;
         res_q      <= res_d;
         wb_valid_q <= wb_valid_d;
         illegal_q  <= illegal_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         retire_q   <= retire_d;
         regs_q     <= regs_d;
      end
   end

   // Held low during reset so nothing is taken while rst is high.
   assign bus.instr_ready  = (state_q == S_IDLE) && !rst;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.illegal      = illegal_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_rv_alu_core.sv
// Directed vector bench for rv_alu_core (XLEN=32, NUM_REGS=32).
// Vectors run back to back, then a reset-during-EXEC sequence.
module tb_rv_alu_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rv_alu_core_if #(.XLEN(32)) bus ();

   rv_alu_core #(.XLEN(32), .NUM_REGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        ill;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [31:0] w, output logic v,
                        output logic il, output logic [4:0] rd,
                        output logic [31:0] d, output logic [31:0] cnt);
      int n;
      @(negedge clk);
      check("ready_idle", 64'(bus.instr_ready), 64'd1);
      n = 0;
      while (!bus.instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready)
         check("ready_timeout", 64'd0, 64'd1);
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      @(posedge clk);
      #1;
      // Still valid but a different word: must be ignored while busy.
      bus.instr = 32'h7FF00F93;
      check("busy_ready", 64'(bus.instr_ready), 64'd0);
      check("no_pulse_t0", 64'({bus.wb_valid, bus.illegal}), 64'd0);
      for (int k = 1; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("no_early_pulse", 64'({bus.wb_valid, bus.illegal}), 64'd0);
      end
      @(posedge clk);
      #1;
      v   = bus.wb_valid;
      il  = bus.illegal;
      rd  = bus.wb_rd;
      d   = bus.wb_data;
      cnt = bus.retire_count;
   endtask

   logic        v, il;
   logic [4:0]  rd;
   logic [31:0] d, cnt;

   initial begin
      vecs[0]  = '{32'h00500093, 1'b0, 5'd1,  32'h00000005, 32'd1};
      vecs[1]  = '{32'hFFD00113, 1'b0, 5'd2,  32'hFFFFFFFD, 32'd2};
      vecs[2]  = '{32'h402081B3, 1'b0, 5'd3,  32'h00000008, 32'd3};
      vecs[3]  = '{32'h40115213, 1'b0, 5'd4,  32'hFFFFFFFE, 32'd4};
      vecs[4]  = '{32'h001132B3, 1'b0, 5'd5,  32'h00000000, 32'd5};
      vecs[5]  = '{32'h00700013, 1'b0, 5'd0,  32'h00000007, 32'd6};
      vecs[6]  = '{32'h00000313, 1'b0, 5'd6,  32'h00000000, 32'd7};
      vecs[7]  = '{32'h00000000, 1'b1, 5'd6,  32'h00000000, 32'd7};
      vecs[8]  = '{32'h02009393, 1'b1, 5'd6,  32'h00000000, 32'd7};
      vecs[9]  = '{32'h00038413, 1'b0, 5'd8,  32'h00000000, 32'd8};
      vecs[10] = '{32'h001124B3, 1'b0, 5'd9,  32'h00000001, 32'd9};
      vecs[11] = '{32'h00115533, 1'b0, 5'd10, 32'h07FFFFFF, 32'd10};
      vecs[12] = '{32'hFFF0B593, 1'b0, 5'd11, 32'h00000001, 32'd11};
      vecs[13] = '{32'h0F014613, 1'b0, 5'd12, 32'hFFFFFF0D, 32'd12};
      vecs[14] = '{32'h021086B3, 1'b1, 5'd12, 32'hFFFFFF0D, 32'd12};
      vecs[15] = '{32'h00109733, 1'b0, 5'd14, 32'h000000A0, 32'd13};

      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(bus.instr_ready), 64'd0);
      check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      check("rst_illegal", 64'(bus.illegal), 64'd0);
      check("rst_count", 64'(bus.retire_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].instr, v, il, rd, d, cnt);
         check($sformatf("v%0d_wb_valid", i), 64'(v), 64'(!vecs[i].ill));
         check($sformatf("v%0d_illegal", i), 64'(il), 64'(vecs[i].ill));
         check($sformatf("v%0d_wb_rd", i), 64'(rd), 64'(vecs[i].rd));
         check($sformatf("v%0d_wb_data", i), 64'(d), 64'(vecs[i].data));
         check($sformatf("v%0d_count", i), 64'(cnt), 64'(vecs[i].cnt));
      end
      bus.instr_valid = 1'b0;

      // Reset arriving while ADDI x1,x0,9 sits in EXEC.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = 32'h00900093;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      rst             = 1'b1;
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_hold_ready", 64'(bus.instr_ready), 64'd0);
         @(posedge clk);
         #1;
         check("rst_no_pulse", 64'({bus.wb_valid, bus.illegal}), 64'd0);
      end
      rst             = 1'b0;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(bus.instr_ready), 64'd1);
      check("post_rst_count", 64'(bus.retire_count), 64'd0);
      check("post_rst_wb_rd", 64'(bus.wb_rd), 64'd0);
      check("post_rst_wb_data", 64'(bus.wb_data), 64'd0);

      issue(32'h00008813, v, il, rd, d, cnt);
      check("x1_cleared_valid", 64'(v), 64'd1);
      check("x1_cleared_data", 64'(d), 64'd0);
      check("x1_cleared_count", 64'(cnt), 64'd1);
      issue(32'h00010893, v, il, rd, d, cnt);
      check("x2_cleared_rd", 64'(rd), 64'd17);
      check("x2_cleared_data", 64'(d), 64'd0);
      check("x2_cleared_count", 64'(cnt), 64'd2);
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      check("final_no_pulse", 64'({bus.wb_valid, bus.illegal}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
